// File: rtl/led_pkg.sv
// Shared types and constants for the LED display arbiter.
// Digit codes: bit4 = dot, bits3:0 = hex value.
package led_pkg;

    localparam int N_DIG = 8;

    typedef logic [4:0] dig_code_t;

    localparam dig_code_t DIG_RESET = 5'h18;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        COMMIT
    } arb_state_t;

    // Round-robin pick; last = index of the requester served most recently.
    function automatic logic [1:0] rr_pick(
        input logic [1:0] req,
        input logic       last
    );
        logic [1:0] pick;
        pick = 2'b00;
        unique case (1'b1)
            (req == 2'b11): pick = last ? 2'b01 : 2'b10;
            (req == 2'b01): pick = 2'b01;
            (req == 2'b10): pick = 2'b10;
            default:        pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Digit scan timing: prescaler, digit pointer, blanking window, cs.
// cs is dark for BLANK_CYC clocks after every digit advance.
module led_scan_timer #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [2:0] pointer,
    output logic [7:0] cs
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    logic [PW-1:0] pre_q;
    logic [BW-1:0] blk_q;

    assign tick = (pre_q == PW'(DIV - 1));

    // Prescaler counts 0..DIV-1 and restarts on the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // Digit pointer advances once per tick, wrapping 7 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pointer <= 3'd0;
        end else if (tick) begin
            pointer <= pointer + 3'd1;
        end
    end

    // Blanking countdown; starts dark out of reset so cs is 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_q <= BW'(BLANK_CYC);
        end else if (tick) begin
            blk_q <= BW'(BLANK_CYC);
        end else if (blk_q != '0) begin
            blk_q <= blk_q - BW'(1);
        end
    end

    // Light the selected digit only outside the blanking window.
    always_comb begin
        cs = 8'h00;
        if (blk_q == '0) begin
            cs = 8'(1) << pointer;
        end
    end

endmodule

// File: rtl/led_disp_arbiter.sv
// Two-requester arbiter for the 8-digit LED display with a shadow
// frame that is committed atomically at the scan wrap.
module led_disp_arbiter
    import led_pkg::*;
#(
    parameter int F_CLK     = 50000000,
    parameter int F_SCAN    = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [1:0] wr_valid,
    input  logic [9:0] wr_data,
    output logic [1:0] wr_ready,
    output logic       frame_swap,
    output logic [7:0] cs,
    output logic [4:0] dig_code
);

    localparam int DIV = F_CLK / F_SCAN;

    arb_state_t state_q;
    arb_state_t state_d;

    logic [1:0] gnt_q;
    logic       last_q;
    logic [2:0] beat_q;
    dig_code_t  active_q [N_DIG];
    dig_code_t  shadow_q [N_DIG];
    dig_code_t  dig_q;

    logic       tick;
    logic [2:0] pointer;
    logic [2:0] next_ptr;
    dig_code_t  beat_data;
    logic       req_g;
    logic       valid_g;
    logic       grant_ld;
    logic       accept;
    logic       abort;
    logic       commit;

    led_scan_timer #(
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .pointer (pointer),
        .cs      (cs)
    );

    assign next_ptr  = pointer + 3'd1;
    assign beat_data = gnt_q[1] ? wr_data[9:5] : wr_data[4:0];
    assign req_g     = |(req & gnt_q);
    assign valid_g   = |(wr_valid & gnt_q);
    assign gnt       = gnt_q;
    assign dig_code  = dig_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake outputs and datapath strobes.
    always_comb begin
        state_d    = state_q;
        grant_ld   = 1'b0;
        accept     = 1'b0;
        abort      = 1'b0;
        commit     = 1'b0;
        wr_ready   = 2'b00;
        frame_swap = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_ld = 1'b1;
                    state_d  = BURST;
                end
            end
            BURST: begin
                wr_ready = gnt_q;
                if (!req_g) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (valid_g) begin
                    accept = 1'b1;
                    if (beat_q == 3'd7) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (tick && pointer == 3'd7) begin
                    commit     = 1'b1;
                    frame_swap = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant, last-served and beat counter bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q  <= 2'b00;
            last_q <= 1'b1;
            beat_q <= 3'd0;
        end else begin
            if (grant_ld) begin
                gnt_q  <= rr_pick(req, last_q);
                beat_q <= 3'd0;
            end else if (abort) begin
                gnt_q <= 2'b00;
            end else if (commit) begin
                gnt_q  <= 2'b00;
                last_q <= gnt_q[1];
            end
            if (accept && beat_q != 3'd7) begin
                beat_q <= beat_q + 3'd1;
            end
        end
    end

    // Shadow frame captures accepted beats in order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_DIG; i++) begin
                shadow_q[i] <= DIG_RESET;
            end
        end else if (accept) begin
            shadow_q[beat_q] <= beat_data;
        end
    end

    // Active frame swaps only at commit; dig_code follows the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_DIG; i++) begin
                active_q[i] <= DIG_RESET;
            end
            dig_q <= DIG_RESET;
        end else if (commit) begin
            for (int i = 0; i < N_DIG; i++) begin
                active_q[i] <= shadow_q[i];
            end
            dig_q <= shadow_q[0];
        end else if (tick) begin
            dig_q <= active_q[next_ptr];
        end
    end

endmodule

// File: tb/tb_led_disp_arbiter.sv
// Randomized bench for led_disp_arbiter with a frame-level reference
// model; DIV=8, BLANK_CYC=2.
module tb_led_disp_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] wr_valid;
    logic [9:0] wr_data;
    logic [1:0] wr_ready;
    logic       frame_swap;
    logic [7:0] cs;
    logic [4:0] dig_code;

    always #5 clk = ~clk;

    led_disp_arbiter #(
        .F_CLK     (800),
        .F_SCAN    (100),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .frame_swap (frame_swap),
        .cs         (cs),
        .dig_code   (dig_code)
    );

    int checks = 0;
    int errors = 0;
    int t;

    // Reference model: displayed frame, pending frame, who holds the display.
    logic [4:0] m_active [8];
    logic [4:0] m_shadow [8];
    int         m_phase;   // 0 free, 1 receiving, 2 waiting for wrap
    int         m_g;
    int         m_last;
    int         m_beats;

    // Requester behaviour.
    bit         want     [2];
    int         sent     [2];
    int         vmode    [2];
    int         abort_at [2];
    int         reload   [2];
    logic [4:0] frame    [2][8];

    int         swaps;
    int         swap_t;
    int         dig0f;
    logic [1:0] prev_gnt;
    logic [1:0] glog [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)",
                   tag, obs, exp, t);
        end
    endtask

    function automatic logic [4:0] rnd_code();
        logic [4:0] v;
        v = 5'($urandom_range(0, 31));
        if (v == 5'h0F) v = 5'h0E;
        return v;
    endfunction

    task automatic new_frame(input int i);
        for (int k = 0; k < 8; k++) frame[i][k] = rnd_code();
    endtask

    task automatic setup(input int i, input int vm, input int ab,
                         input int rl);
        sent[i]     = 0;
        vmode[i]    = vm;
        abort_at[i] = ab;
        reload[i]   = rl;
        want[i]     = 1'b1;
    endtask

    task automatic quiet(input int i);
        want[i]     = 1'b0;
        sent[i]     = 8;
        vmode[i]    = 0;
        abort_at[i] = -1;
        reload[i]   = 0;
    endtask

    task automatic drive();
        logic v;
        logic [4:0] d;
        req = {want[1], want[0]};
        for (int i = 0; i < 2; i++) begin
            case (vmode[i])
                1:       v = (t % 2 == 0) && (sent[i] < 8);
                2:       v = ($urandom_range(0, 1) == 1) && (sent[i] < 8);
                3:       v = 1'b1;
                default: v = (sent[i] < 8);
            endcase
            d = (vmode[i] == 3) ? 5'h0F : frame[i][sent[i] & 7];
            wr_valid[i]     = v;
            wr_data[5*i +: 5] = d;
        end
    endtask

    task automatic check();
        int ptr, ph;
        logic [1:0] eg, er;
        logic es;
        ptr = (t / 8) % 8;
        ph  = t % 8;
        eg  = (m_phase != 0) ? 2'(1 << m_g) : 2'b00;
        er  = (m_phase == 1) ? eg : 2'b00;
        es  = (m_phase == 2) && (ph == 7) && (ptr == 7);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("wr_ready", 32'(wr_ready), 32'(er));
        chk("frame_swap", 32'(frame_swap), 32'(es));
        chk("cs", 32'(cs), (ph < 2) ? 32'd0 : (32'd1 << ptr));
        chk("dig_code", 32'(dig_code), 32'(m_active[ptr]));
        if (frame_swap === 1'b1) begin
            swaps++;
            swap_t = t;
        end
        if (dig_code === 5'h0F) dig0f++;
        if (gnt != 2'b00 && prev_gnt == 2'b00) glog.push_back(gnt);
        prev_gnt = gnt;
    endtask

    task automatic requester_done(input int g);
        if (reload[g] > 0) begin
            reload[g]--;
            new_frame(g);
            sent[g] = 0;
        end else begin
            want[g] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit wrap;
        wrap = (t % 8 == 7) && ((t / 8) % 8 == 7);
        case (m_phase)
            0: begin
                if (req != 2'b00) begin
                    if (req == 2'b11) m_g = (m_last == 0) ? 1 : 0;
                    else              m_g = req[1] ? 1 : 0;
                    m_phase = 1;
                    m_beats = 0;
                end
            end
            1: begin
                if (!req[m_g]) begin
                    m_phase = 0;
                end else if (wr_valid[m_g]) begin
                    m_shadow[m_beats] = wr_data[5*m_g +: 5];
                    m_beats++;
                    sent[m_g]++;
                    if (abort_at[m_g] >= 0 && sent[m_g] >= abort_at[m_g])
                        want[m_g] = 1'b0;
                    if (m_beats == 8) m_phase = 2;
                end
            end
            default: begin
                if (wrap) begin
                    m_active = m_shadow;
                    m_last   = m_g;
                    m_phase  = 0;
                    requester_done(m_g);
                end
            end
        endcase
    endtask

    task automatic cycle();
        drive();
        check();
        model_step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_done(input int bound, input string tag);
        int k = 0;
        while ((want[0] || want[1] || m_phase != 0) && k < bound) begin
            cycle();
            k++;
        end
        chk(tag, 32'(k < bound), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        quiet(0);
        quiet(1);
        req      = 2'b00;
        wr_valid = 2'b00;
        wr_data  = '0;
        #1;
        chk("rst_cs", 32'(cs), 32'd0);
        chk("rst_dig", 32'(dig_code), 32'h18);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rdy", 32'(wr_ready), 32'd0);
        chk("rst_swap", 32'(frame_swap), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            m_active[k] = 5'h18;
            m_shadow[k] = 5'h18;
        end
        m_phase  = 0;
        m_g      = 0;
        m_last   = 1;
        m_beats  = 0;
        prev_gnt = 2'b00;
        t        = 0;
    endtask

    initial begin
        rst = 1'b1;
        do_reset();
        run(72);

        // Single frame 00..07 from requester 0.
        for (int k = 0; k < 8; k++) frame[0][k] = 5'(k);
        swaps = 0;
        setup(0, 0, -1, 0);
        run_done(300, "single_done");
        run(64);
        chk("single_swaps", 32'(swaps), 32'd1);

        // Reset in the middle of a burst.
        new_frame(1);
        setup(1, 0, -1, 0);
        run(4);
        do_reset();
        run(70);

        // Contention; requester 0 re-requests right after its commit.
        new_frame(0);
        new_frame(1);
        glog.delete();
        swaps = 0;
        setup(0, 0, -1, 1);
        setup(1, 0, -1, 0);
        run_done(1000, "cont_done");
        run(64);
        chk("cont_swaps", 32'(swaps), 32'd3);
        chk("cont_nglog", 32'(glog.size()), 32'd3);
        if (glog.size() == 3) begin
            chk("cont_g0", 32'(glog[0]), 32'b01);
            chk("cont_g1", 32'(glog[1]), 32'b10);
            chk("cont_g2", 32'(glog[2]), 32'b01);
        end

        // Abort after three beats of 1A.
        for (int k = 0; k < 8; k++) frame[1][k] = 5'h1A;
        swaps = 0;
        setup(1, 0, 3, 0);
        run_done(200, "abort_done");
        run(70);
        chk("abort_swaps", 32'(swaps), 32'd0);

        // Backpressure with a noisy ungranted requester.
        new_frame(0);
        swaps = 0;
        dig0f = 0;
        setup(0, 1, -1, 0);
        vmode[1] = 3;
        run_done(400, "bp_done");
        run(64);
        chk("bp_swaps", 32'(swaps), 32'd1);
        chk("bp_no0f", 32'(dig0f), 32'd0);
        quiet(1);

        // Last beat lands while the pointer is at digit 2.
        while (t % 64 != 10) cycle();
        new_frame(0);
        swaps = 0;
        setup(0, 0, -1, 0);
        run_done(200, "late_done");
        chk("late_swaps", 32'(swaps), 32'd1);
        chk("late_swap_t", 32'(swap_t % 64), 32'd63);
        run(64);

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            new_frame(0);
            new_frame(1);
            setup(0, 2, ($urandom_range(0, 2) == 0) ?
                  int'($urandom_range(1, 7)) : -1,
                  int'($urandom_range(0, 1)));
            setup(1, 2, ($urandom_range(0, 2) == 0) ?
                  int'($urandom_range(1, 7)) : -1,
                  int'($urandom_range(0, 1)));
            run(int'($urandom_range(0, 20)));
            run_done(4000, "rand_done");
        end
        run(64);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/led_disp_arbiter.md
Name: led_disp_arbiter

Overview:
Shares the 8-digit multiplexed LED display between two requesters. Each requester obtains a round-robin grant and bursts a full 8-digit frame into a shadow buffer. The frame becomes visible atomically at the scan wrap, so the display never tears. The block also generates scan timing (digit select plus blanking) and presents the current digit code to the downstream 7-segment decoder.

Parameters:
F_CLK, 50000000, input clock frequency in Hz.
F_SCAN, 1000, digit advance rate in Hz; divider DIV = F_CLK/F_SCAN, minimum 4.
BLANK_CYC, 16, clocks of all-off cs after each digit advance; must be < DIV.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
req  in  2  per-requester frame request; level, held until grant release.
gnt  out  2  one-hot grant; at most one bit set.
wr_valid  in  2  per-requester beat valid.
wr_data  in  10  requester i beat on [5i+4:5i]; bit4 = dot, bits3:0 = hex digit.
wr_ready  out  2  per-requester beat ready.
frame_swap  out  1  one-cycle pulse when a shadow frame is committed.
cs  out  8  one-hot digit select, bit k = digit k; all-zero while blanking.
dig_code  out  5  code of the currently selected digit, to the decoder.

Behaviour:
- Reset values: gnt=0, wr_ready=0, frame_swap=0, cs=0, dig_code=5'h18, scan pointer=0, prescaler=0, last-served=1 (requester 0 wins first), all active and shadow entries=5'h18, FSM=IDLE. Reset mid-burst discards the shadow contents.
- Scan timing:
  - Prescaler counts 0..DIV-1. A tick is asserted on the terminal count.
  - On tick, pointer advances 0→7, then wraps 7→0, and dig_code loads the next digit.
  - cs=0 for the BLANK_CYC clocks starting the cycle after the tick. After that, cs = 1<<pointer until the next tick.
- FSM states are IDLE, BURST and COMMIT.
  - IDLE, arbitration:
    - If req has only one bit set, that requester is granted.
    - If both bits are set, the requester not in last-served is granted.
    - The gnt bit is registered (1 cycle after req), and the FSM enters BURST with beat counter=0.
  - BURST:
    - wr_ready[g]=1 for the granted requester only; the other requester's valid is ignored.
    - A beat is accepted on wr_valid[g]&wr_ready[g]: shadow[beat] <= data, beat++.
    - Accepting beat 7 deasserts wr_ready the next cycle and moves to COMMIT.
    - If req[g] drops during BURST, the burst aborts: gnt=0, no swap, back to IDLE. Shadow writes already made are discarded because active is untouched.
  - COMMIT:
    - wr_ready=0; gnt is held. Wait for a tick with pointer==7.
    - On that tick: active <= shadow, dig_code <= shadow[0] (the new frame shows from digit 0), frame_swap=1 for one cycle.
    - The next cycle: gnt=0, last-served=g, state=IDLE.
    - A req drop in COMMIT does not cancel the commit.
- Latency: the commit wait is ≤ 8*DIV clocks after the last beat. A new grant can occur 1 cycle after release.
- Active frame is written only at commit. dig_code always reflects the active frame, except that the commit tick selects shadow[0].
- Width rule: beat counter is 3 bits and terminates at 7 with no wrap into a 9th beat. Prescaler width is $clog2(DIV).

Decomposition:
- Package led_pkg:
  - N_DIG=8.
  - typedef logic[4:0] dig_code_t.
  - DIG_RESET=5'h18.
  - enum arb_state_t {IDLE, BURST, COMMIT}.
- Sub-module led_scan_timer contains the prescaler, pointer, tick, blanking and cs generation. Outputs: tick, pointer, cs.
- The arbiter, FSM and buffers stay in the top module.

Test Plan:
- Bench parameters for all scenarios: F_CLK=800, F_SCAN=100 (DIV=8), BLANK_CYC=2.
- Reset: assert rst mid-run → cs=0, dig_code=5'h18, gnt=0. After release, the cs sequence is 01,02,...,80,01 with each digit lit 6 of 8 clocks, and dig_code=5'h18 on every digit.
- Single frame: req=01, stream 8 beats 5'h00..5'h07 with valid held high → wr_ready high exactly 8 accepted cycles. frame_swap pulses once on the pointer 7→0 tick. dig_code then shows 00,01,...,07 in cs order.
- Contention: req=11 from IDLE after reset → gnt=01 first. After its swap, gnt=10 the cycle after release. Requester 1 is not stalled by a re-asserted req[0].
- Abort: req=10, 3 beats 5'h1A, then req drops → gnt=0 next cycle, no frame_swap, display unchanged.
- Backpressure and isolation: granted requester toggles wr_valid every other cycle while the ungranted requester drives valid=1 with 5'h0F → exactly 8 beats from the granted requester only are captured. No 5'h0F appears on dig_code.
- Commit timing: last beat accepted while pointer=2 → no swap until the tick with pointer 7→0 (about 5 scan periods later). Until then digits 3..7 keep old codes and gnt stays held.
